// File: rtl/neuron_pkg.sv
// Shared constants and state encoding for the neuron feeder block.
// FP_ONE/FP_TWO are reference operands for directed stimulus; the RTL never does arithmetic.
package neuron_pkg;

    localparam int DW      = 32;
    localparam int N_PAIRS = 4;
    localparam int IDX_W   = $clog2(N_PAIRS);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [31:0] FP_ONE = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO = 32'h4000_0000;

endpackage

// File: rtl/nrn_watchdog.sv
// Cycle counter for the WAIT phase: cleared outside WAIT, counts while enabled,
// and flags expiry on the cycle the count reaches TIMEOUT-1.
module nrn_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int            CW   = 16;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/neuron_feeder.sv
// Packs four serial (x, w) pairs into the neuron operand bus, fires it, waits for
// a fresh done edge under a watchdog, and returns the result over valid/ready.
module neuron_feeder #(
    parameter int DW      = neuron_pkg::DW,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_w,
    output logic [DW-1:0] x1,
    output logic [DW-1:0] x2,
    output logic [DW-1:0] x3,
    output logic [DW-1:0] x4,
    output logic [DW-1:0] w1,
    output logic [DW-1:0] w2,
    output logic [DW-1:0] w3,
    output logic [DW-1:0] w4,
    output logic          nrn_start,
    input  logic          nrn_done,
    input  logic [DW-1:0] nrn_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_err
);

    import neuron_pkg::*;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [DW-1:0]      r_x [N_PAIRS];
    logic [DW-1:0]      r_w [N_PAIRS];
    logic               r_start;
    logic               r_done_q;
    logic               r_out_valid;
    logic [DW-1:0]      r_out_data;
    logic               r_out_err;

    logic               w_done_rise;
    logic               w_expire;
    logic               w_in_wait;

    assign w_in_wait   = (r_state == WAIT);
    // A done level left over from an earlier job must not complete this one.
    assign w_done_rise = nrn_done && !r_done_q;

    nrn_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!w_in_wait),
        .i_en     (w_in_wait),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_idx       <= '0;
            r_start     <= 1'b0;
            r_done_q    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            // NOTE: the operand bank is a handful of flops driving the neuron
            // directly, so it is cleared; a true RAM here would not be reset.
            for (int i = 0; i < N_PAIRS; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
        end else begin
            r_done_q <= nrn_done;
            r_start  <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        r_x[r_idx] <= in_x;
                        r_w[r_idx] <= in_w;
                        if (r_idx == IDX_W'(N_PAIRS - 1)) begin
                            r_idx   <= '0;
                            r_start <= 1'b1;
                            r_state <= FIRE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Done edge takes priority over a coincident expiry.
                    if (w_done_rise) begin
                        r_out_data  <= nrn_result;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (w_expire) begin
                        r_out_data  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= LOAD;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == LOAD);
    assign nrn_start = r_start;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

    assign x1 = r_x[0];
    assign x2 = r_x[1];
    assign x3 = r_x[2];
    assign x4 = r_x[3];
    assign w1 = r_w[0];
    assign w2 = r_w[1];
    assign w3 = r_w[2];
    assign w4 = r_w[3];

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed scenarios for neuron_feeder with a result scoreboard; the bench plays
// the neuron by driving nrn_done/nrn_result at chosen cycles after nrn_start.
module tb_neuron_feeder;

    import neuron_pkg::*;

    localparam int TB_TIMEOUT = 8;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_w;
    logic [31:0] x1, x2, x3, x4;
    logic [31:0] w1, w2, w3, w4;
    logic        nrn_start;
    logic        nrn_done;
    logic [31:0] nrn_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    exp_t sb_q[$];
    int   n_pass;
    int   n_total;
    int   acc_cnt;
    int   start_cnt;

    neuron_feeder #(
        .DW      (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_w       (in_w),
        .x1         (x1),
        .x2         (x2),
        .x3         (x3),
        .x4         (x4),
        .w1         (w1),
        .w2         (w2),
        .w3         (w3),
        .w4         (w4),
        .nrn_start  (nrn_start),
        .nrn_done   (nrn_done),
        .nrn_result (nrn_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_cnt++;
        if (nrn_start) start_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [31:0] x, input logic [31:0] w);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        n_total++;
        if (!in_ready) $display("FAIL send_ready_wait: in_ready got %0b want 1", in_ready);
        else n_pass++;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load4(input logic [3:0][31:0] xs, input logic [3:0][31:0] ws, input bit toggle);
        for (int i = 0; i < 4; i++) begin
            if (toggle && i > 0) begin
                in_valid = 1'b0;
                tick();
            end
            send_pair(xs[i], ws[i]);
        end
    endtask

    task automatic collect(input int budget);
        int   guard;
        exp_t e;
        guard = 0;
        while (!out_valid && guard < budget) begin
            tick();
            guard++;
        end
        n_total++;
        if (!out_valid) begin
            $display("FAIL collect_wait: out_valid got %0b want 1", out_valid);
        end else if (sb_q.size() == 0) begin
            $display("FAIL collect_sb: unexpected result got %h want none", out_data);
        end else begin
            e = sb_q.pop_front();
            if (out_data !== e.data || out_err !== e.err)
                $display("FAIL collect_result: got data=%h err=%0b want data=%h err=%0b",
                         out_data, out_err, e.data, e.err);
            else n_pass++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL collect_release: got valid=%0b in_ready=%0b want valid=0 in_ready=1",
                     out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_total++;
        if ({x1, x2, x3, x4, w1, w2, w3, w4, out_data} !== '0 ||
            {nrn_start, out_valid, out_err} !== 3'b000 || in_ready !== 1'b1)
            $display("FAIL reset_state: got start=%0b valid=%0b err=%0b data=%h in_ready=%0b want 0/0/0/0/1",
                     nrn_start, out_valid, out_err, out_data, in_ready);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0][31:0] xs, ws;
        xs = {4{FP_ONE}};
        ws = {4{FP_TWO}};
        acc_cnt   = 0;
        start_cnt = 0;
        load4(xs, ws, 1'b0);
        n_total++;
        if (nrn_start !== 1'b1) $display("FAIL basic_start: nrn_start got %0b want 1", nrn_start);
        else n_pass++;
        n_total++;
        if ({x1, x2, x3, x4} !== {4{FP_ONE}} || {w1, w2, w3, w4} !== {4{FP_TWO}})
            $display("FAIL basic_operands: got x1=%h w1=%h x4=%h w4=%h want %h/%h", x1, w1, x4, w4, FP_ONE, FP_TWO);
        else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL basic_wait: got valid=%0b in_ready=%0b want 0/0", out_valid, in_ready);
        else n_pass++;
        nrn_done   = 1'b1;
        nrn_result = 32'h4100_0000;
        sb_q.push_back('{data: 32'h4100_0000, err: 1'b0});
        tick();
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL basic_latency: out_valid got %0b want 1", out_valid);
        else n_pass++;
        n_total++;
        if (start_cnt !== 1) $display("FAIL basic_start_count: got %0d want 1", start_cnt);
        else n_pass++;
        collect(4);
        nrn_done = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0][31:0] xs, ws;
        bit bad;
        xs[0] = 32'h3F80_0000; xs[1] = 32'h4000_0000; xs[2] = 32'h4040_0000; xs[3] = 32'h4080_0000;
        ws[0] = 32'h3E80_0000; ws[1] = 32'h3F00_0000; ws[2] = 32'h3FC0_0000; ws[3] = 32'h4020_0000;
        acc_cnt = 0;
        load4(xs, ws, 1'b1);
        n_total++;
        if ({x1, x2, x3, x4} !== {xs[0], xs[1], xs[2], xs[3]} || {w1, w2, w3, w4} !== {ws[0], ws[1], ws[2], ws[3]})
            $display("FAIL bp_slot_order: got x=%h %h %h %h w=%h %h %h %h", x1, x2, x3, x4, w1, w2, w3, w4);
        else n_pass++;
        in_valid = 1'b1;
        in_x     = 32'hFFFF_FFFF;
        in_w     = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) tick();
        nrn_done   = 1'b1;
        nrn_result = 32'h4120_0000;
        sb_q.push_back('{data: 32'h4120_0000, err: 1'b0});
        tick();
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== 32'h4120_0000 || in_ready !== 1'b0) bad = 1'b1;
            tick();
        end
        n_total++;
        if (bad) $display("FAIL bp_hold_stable: got valid=%0b data=%h in_ready=%0b want 1/41200000/0",
                          out_valid, out_data, in_ready);
        else n_pass++;
        in_valid = 1'b0;
        n_total++;
        if (acc_cnt !== 4 || x1 !== xs[0] || w4 !== ws[3])
            $display("FAIL bp_accept_count: got accepts=%0d x1=%h w4=%h want 4/%h/%h", acc_cnt, x1, w4, xs[0], ws[3]);
        else n_pass++;
        collect(2);
        nrn_done = 1'b0;
    endtask

    task automatic test_stale_done();
        logic [3:0][31:0] xs, ws;
        bit bad;
        xs = {4{FP_TWO}};
        ws = {4{FP_ONE}};
        load4(xs, ws, 1'b0);
        tick();
        tick();
        nrn_done   = 1'b1;
        nrn_result = 32'h4040_0000;
        sb_q.push_back('{data: 32'h4040_0000, err: 1'b0});
        tick();
        collect(4);
        xs = {4{32'h3F00_0000}};
        load4(xs, ws, 1'b0);
        nrn_result = 32'hDEAD_BEEF;
        bad = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            if (out_valid !== 1'b0) bad = 1'b1;
            if (c == 3) nrn_done = 1'b0;
            if (c == 5) begin
                nrn_done   = 1'b1;
                nrn_result = 32'h40E0_0000;
                sb_q.push_back('{data: 32'h40E0_0000, err: 1'b0});
            end
            tick();
        end
        n_total++;
        if (bad) $display("FAIL stale_early_capture: out_valid got 1 want 0 before new done edge");
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL stale_capture: out_valid got %0b want 1", out_valid);
        else n_pass++;
        collect(2);
        nrn_done = 1'b0;
    endtask

    task automatic test_timeout();
        logic [3:0][31:0] xs, ws;
        bit bad;
        xs = {4{FP_ONE}};
        ws = {4{FP_ONE}};
        nrn_result = 32'hDEAD_BEEF;
        load4(xs, ws, 1'b0);
        sb_q.push_back('{data: 32'h0, err: 1'b1});
        bad = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (out_valid !== 1'b0) bad = 1'b1;
            tick();
        end
        n_total++;
        if (bad) $display("FAIL timeout_early: out_valid got 1 want 0 before %0d WAIT cycles", TB_TIMEOUT);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL timeout_latency: out_valid got %0b want 1", out_valid);
        else n_pass++;
        collect(2);
    endtask

    task automatic test_done_on_timeout();
        logic [3:0][31:0] xs, ws;
        xs = {4{FP_TWO}};
        ws = {4{FP_TWO}};
        load4(xs, ws, 1'b0);
        for (int c = 0; c < 8; c++) tick();
        nrn_done   = 1'b1;
        nrn_result = 32'h4110_0000;
        sb_q.push_back('{data: 32'h4110_0000, err: 1'b0});
        tick();
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL simul_valid: out_valid got %0b want 1", out_valid);
        else n_pass++;
        collect(2);
        nrn_done = 1'b0;
    endtask

    task automatic test_ready_early();
        logic [3:0][31:0] xs, ws;
        exp_t e;
        xs = {4{32'h4040_0000}};
        ws = {4{FP_ONE}};
        out_ready = 1'b1;
        load4(xs, ws, 1'b0);
        tick();
        tick();
        nrn_done   = 1'b1;
        nrn_result = 32'h4130_0000;
        sb_q.push_back('{data: 32'h4130_0000, err: 1'b0});
        tick();
        n_total++;
        if (out_valid !== 1'b1 || sb_q.size() == 0) begin
            $display("FAIL early_ready_valid: out_valid got %0b want 1", out_valid);
        end else begin
            e = sb_q.pop_front();
            if (out_data !== e.data || out_err !== e.err)
                $display("FAIL early_ready_result: got data=%h err=%0b want data=%h err=%0b",
                         out_data, out_err, e.data, e.err);
            else n_pass++;
        end
        tick();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL early_ready_release: got valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        else n_pass++;
        out_ready = 1'b0;
        nrn_done  = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [3:0][31:0] xs, ws;
        bit bad;
        xs = {4{FP_ONE}};
        ws = {4{32'h4080_0000}};
        load4(xs, ws, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_total++;
        if ({x1, x2, x3, x4, w1, w2, w3, w4, out_data} !== '0 ||
            {nrn_start, out_valid, out_err} !== 3'b000 || in_ready !== 1'b1)
            $display("FAIL midwait_reset: got start=%0b valid=%0b err=%0b x1=%h in_ready=%0b want 0/0/0/0/1",
                     nrn_start, out_valid, out_err, x1, in_ready);
        else n_pass++;
        nrn_result = 32'h4150_0000;
        nrn_done   = 1'b1;
        tick();
        nrn_done = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        n_total++;
        if (bad) $display("FAIL midwait_late_done: got valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        else n_pass++;
        load4(ws, xs, 1'b0);
        n_total++;
        if (x1 !== 32'h4080_0000 || w4 !== FP_ONE)
            $display("FAIL midwait_recover_ops: got x1=%h w4=%h want 40800000/%h", x1, w4, FP_ONE);
        else n_pass++;
        tick();
        nrn_done   = 1'b1;
        nrn_result = 32'h4160_0000;
        sb_q.push_back('{data: 32'h4160_0000, err: 1'b0});
        tick();
        collect(4);
        nrn_done = 1'b0;
        n_total++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        acc_cnt    = 0;
        start_cnt  = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_x       = '0;
        in_w       = '0;
        nrn_done   = 1'b0;
        nrn_result = '0;
        out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_stale_done();
        test_timeout();
        test_done_on_timeout();
        test_ready_early();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
